// File: rtl/load_store_unit_pkg.sv
// Shared size codes, FSM state encoding and the alignment rule for the load/store unit.
package load_store_unit_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_BAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lane[0];
      SIZE_W:  return (lane != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends the load lane, and merges store data
// into a word (whole-word replacement for word stores).
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = word[{lane, 3'b000} +: 8];
    lane_half = lane[1] ? word[31:16] : word[15:0];

    load_val = word;
    case (size)
      SIZE_B:  load_val = {{24{sign_ext & lane_byte[7]}}, lane_byte};
      SIZE_H:  load_val = {{16{sign_ext & lane_half[15]}}, lane_half};
      default: load_val = word;
    endcase

    store_word = word;
    case (size)
      SIZE_B: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      SIZE_H: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store sequencer in front of a word-only data memory.
// Sub-word stores are read-modify-write; misaligned requests abort before any write.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for req; request fields latched on accept
//  ST_LOAD   | memory word read, lane extended into rdata
//  ST_RMW_RD | sub-word store: current memory word captured into merge_q
//  ST_WRITE  | mem_wr high for exactly this cycle
//  ST_DONE   | done pulse, CPU released
//  ST_ERR    | misalign pulse, access dropped without writing
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merge_q;
  logic [DATA_W-1:0] align_word;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] store_word;
  logic              accept;

  assign accept = (state == ST_IDLE) && req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    mem_wr     = 1'b0;
    done       = 1'b0;
    misalign   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          busy = 1'b1;
          if (is_misaligned(size, addr[1:0])) next_state = ST_ERR;
          else if (!we)                       next_state = ST_LOAD;
          else if (size == SIZE_W)            next_state = ST_WRITE;
          else                                next_state = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        busy       = 1'b1;
        next_state = ST_DONE;
      end
      ST_RMW_RD: begin
        busy       = 1'b1;
        next_state = ST_WRITE;
      end
      ST_WRITE: begin
        busy       = 1'b1;
        mem_wr     = 1'b1;
        next_state = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      ST_ERR: begin
        misalign   = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= SIZE_B;
      sign_q  <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        size_q  <= size;
        sign_q  <= sign_ext;
        wdata_q <= wdata;
      end
      if (state == ST_LOAD)   rdata   <= load_val;
      if (state == ST_RMW_RD) merge_q <= mem_dout;
    end
  end

  // In WRITE the lane logic merges into the captured word; otherwise it sees the live read.
  assign align_word = (state == ST_WRITE) ? merge_q : mem_dout;

  lsu_lane_align u_lane_align (
    .word       (align_word),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .sign_ext   (sign_q),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_din  = (state == ST_WRITE) ? store_word : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a word-only data memory and a behavioural reference
// memory; directed scenarios followed by randomized accesses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        misalign;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic [31:0] mem [0:1023];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;

  logic [31:0] ref_mem [0:63];
  logic [31:0] last_rd;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en)       mem[pl_idx] <= pl_val;
    else if (mem_wr) mem[mem_addr[11:2]] <= mem_din;
  end
  assign mem_dout = mem[mem_addr[11:2]];

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .misalign (misalign),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic model_bad(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sx, input logic [1:0] lo);
    logic [31:0] v;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(lo);
      v  = (w >> sh) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = 16 * int'(lo[1]);
      v  = (w >> sh) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [1:0] lo);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd2) return d;
    if (sz == 2'd0) begin
      sh   = 8 * int'(lo);
      mask = 32'hFF << sh;
    end else begin
      sh   = 16 * int'(lo[1]);
      mask = 32'hFFFF << sh;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  // One access starting in the current cycle (c0); keep=1 leaves req high after completion.
  task automatic run(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                     input logic [31:0] d, input bit keep, output logic [31:0] rd_done);
    int e_done, e_mis, e_wr, e_nwr;
    int t_done, t_mis, t_wr, n_wr;
    int idx;
    bit bad, fin;
    idx = int'(a[7:2]);
    bad = model_bad(sz, a);
    e_done = -1; e_mis = -1; e_wr = -1; e_nwr = 0;
    if (bad) begin
      e_mis = 1;
    end else if (!w) begin
      e_done  = 2;
      last_rd = model_load(ref_mem[idx], sz, sx, a[1:0]);
    end else if (sz == 2'd2) begin
      e_wr = 1; e_nwr = 1; e_done = 2;
      ref_mem[idx] = model_store(ref_mem[idx], d, sz, a[1:0]);
    end else begin
      e_wr = 2; e_nwr = 1; e_done = 3;
      ref_mem[idx] = model_store(ref_mem[idx], d, sz, a[1:0]);
    end

    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    t_done = -1; t_mis = -1; t_wr = -1; n_wr = 0; rd_done = 32'h0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_c0", {31'd0, busy}, 32'd1);
      if (k == 1) check("mem_addr", mem_addr, {a[31:2], 2'b00});
      if (mem_wr) begin n_wr++; t_wr = k; end
      if (done && t_done < 0) begin t_done = k; rd_done = rdata; end
      if (misalign && t_mis < 0) t_mis = k;
      fin = done || misalign;
      @(posedge clk); #1;
      if (fin) begin
        if (keep) break;
        req = 1'b0;
      end else if (k == 0 && !keep) begin
        we = $urandom_range(0, 1); size = $urandom_range(0, 3);
        sign_ext = $urandom_range(0, 1); addr = $urandom; wdata = $urandom;
      end
    end

    check("done_cyc", t_done, e_done);
    check("mis_cyc", t_mis, e_mis);
    check("wr_cyc", t_wr, e_wr);
    check("wr_count", n_wr, e_nwr);
    if (!w && !bad) check("rdata_done", rd_done, last_rd);
    check("rdata_hold", rdata, last_rd);
    check("mem_word", mem[{4'd0, a[7:2]}], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] saved;
    int bad_words;

    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0; last_rd = 32'h0;
    pl_en = 1'b1; pl_idx = 10'd0; pl_val = 32'h0;
    for (int i = 0; i < 64; i++) begin
      pl_idx = 10'(i);
      pl_val = $urandom;
      ref_mem[i] = pl_val;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, rd);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    check("t1_lw", rd, 32'hDEADBEEF);

    run(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, rd);
    run(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1'b0, rd);
    check("t2_sb_word", mem[4], 32'h1122AA44);

    run(1'b1, 2'd2, 1'b0, 32'h10, 32'h80223344, 1'b0, rd);
    run(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b0, rd);
    check("t3_lb", rd, 32'hFFFFFF80);
    run(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, rd);
    check("t3_lbu", rd, 32'h00000080);
    run(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0, rd);
    check("t3_lh", rd, 32'hFFFF8022);
    run(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    check("t3_lhu", rd, 32'h00003344);

    run(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 1'b0, rd);
    run(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 1'b0, rd);
    run(1'b1, 2'd3, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, rd);
    check("t4_mem", mem[4], 32'h80223344);

    // Reset while a byte store sits in its read phase.
    saved = mem[4];
    req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h11; wdata = 32'h55;
    @(negedge clk);
    @(posedge clk); #1;
    check("t5_busy_rmw", {31'd0, busy}, 32'd1);
    rst = 1'b1; req = 1'b0;
    #1;
    check("t5_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_rdata", rdata, 32'h0);
    last_rd = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    check("t5_mem", mem[4], saved);
    rst = 1'b0;
    @(posedge clk); #1;
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, rd);
    check("t5_after", rd, saved);

    run(1'b1, 2'd2, 1'b0, 32'h20, 32'h0BADF00D, 1'b1, rd);
    run(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, rd);
    check("t6_back2back", rd, 32'h0BADF00D);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] ra;
      ra = $urandom & 32'hFFFF_F0FF;
      run(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          ra, $urandom, 1'b0, rd);
    end

    bad_words = 0;
    for (int i = 0; i < 64; i++)
      if (mem[i] !== ref_mem[i]) bad_words++;
    check("mem_sweep", bad_words, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
